led_addr_seq: RTL and testbench

Address sequencer that sits directly upstream of the LED pattern ROM (the single-port 4-bit-wide BlockRAM read at 200 MHz).
- Divides clk into a step tick and advances a 12-bit ROM address up or down, with wrap.
- Drives the ROM address and enable, and gives the consumer a strobe marking when ROM data is valid.
- Holds the LED pattern while paused; clears it in idle.

---
 rtl/led_addr_seq.sv | 138 +++++++++++++
 tb/tb_led_addr_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_addr_seq.sv
// Address sequencer feeding the LED pattern ROM: prescaled up/down address stepping with wrap,
// ROM enable, step/rd_valid/wrap strobes. Define LED_SEQ_ONESHOT_EN to stop at the wrap point instead.
module led_addr_seq #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned ADDR_MIN = 0,
  parameter int unsigned ADDR_MAX = 4095
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              dir,
  output logic [ADDR_W-1:0] addr,
  output logic              en,
  output logic              step,
  output logic              rd_valid,
  output logic              wrap,
  output logic              busy
);

  localparam int unsigned       CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] A_MIN    = ADDR_W'(ADDR_MIN);
  localparam logic [ADDR_W-1:0] A_MAX    = ADDR_W'(ADDR_MAX);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              en_q, en_d;
  logic              step_q, step_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wrap_q, wrap_d;
  logic              busy_q, busy_d;
  logic              tick;
  logic              at_end;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    tick    = (cnt_q == CNT_LAST);
    at_end  = dir ? (addr_q == A_MIN) : (addr_q == A_MAX);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // Load the direction-dependent start address and read the ROM at once.
        if (start && !stop) begin
          state_d = S_RUN;
          addr_d  = dir ? A_MAX : A_MIN;
          step_d  = 1'b1;
        end
      end

      S_RUN: begin
        if (stop) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          cnt_d = '0;
          if (at_end) begin
            wrap_d = 1'b1;
`ifdef LED_SEQ_ONESHOT_EN
            state_d = S_IDLE;
            addr_d  = A_MIN;
`else
            addr_d  = dir ? A_MAX : A_MIN;
            step_d  = 1'b1;
`endif
          end else begin
            addr_d = dir ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
            step_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          addr_d  = A_MIN;
          cnt_d   = '0;
        end else if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        addr_d  = A_MIN;
        cnt_d   = '0;
      end
    endcase

    en_d       = (state_d != S_IDLE);
    busy_d     = (state_d != S_IDLE);
    // ROM data arrives one cycle after the address; drop it if we have gone idle.
    rd_valid_d = step_q && (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= A_MIN;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      step_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      wrap_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      step_q     <= step_d;
      rd_valid_q <= rd_valid_d;
      wrap_q     <= wrap_d;
      busy_q     <= busy_d;
    end
  end

  assign addr     = addr_q;
  assign en       = en_q;
  assign step     = step_q;
  assign rd_valid = rd_valid_q;
  assign wrap     = wrap_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_led_addr_seq.sv
// Bench for led_addr_seq: directed scenarios then random start/stop/dir traffic, all checked
// every cycle against a mode/countdown reference model using modular address arithmetic.
module tb_led_addr_seq;

  localparam int TD   = 4;
  localparam int AW   = 12;
  localparam int AMIN = 0;
  localparam int AMAX = 7;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          dir = 1'b0;
  logic [AW-1:0] addr;
  logic          en;
  logic          step;
  logic          rd_valid;
  logic          wrap;
  logic          busy;

  always #5 clk = ~clk;

  led_addr_seq #(
    .TICK_DIV(TD),
    .ADDR_W  (AW),
    .ADDR_MIN(AMIN),
    .ADDR_MAX(AMAX)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .dir     (dir),
    .addr    (addr),
    .en      (en),
    .step    (step),
    .rd_valid(rd_valid),
    .wrap    (wrap),
    .busy    (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: operating mode, cycles left until the next step, expected strobes.
  int m_mode;
  int m_addr;
  int m_cd;
  bit m_step;
  bit m_rdv;
  bit m_wrap;

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_addr = AMIN;
    m_cd   = TD;
    m_step = 1'b0;
    m_rdv  = 1'b0;
    m_wrap = 1'b0;
  endfunction

  function automatic void model_edge(bit s, bit p, bit d);
    bit prev;
    int n;
    int nxt;
    prev   = m_step;
    n      = AMAX - AMIN + 1;
    m_step = 1'b0;
    m_wrap = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (s && !p) begin
          m_mode = M_RUN;
          m_addr = d ? AMAX : AMIN;
          m_step = 1'b1;
          m_cd   = TD;
        end
      end
      M_RUN: begin
        if (p) begin
          m_mode = M_PAUSE;
        end else begin
          m_cd = m_cd - 1;
          if (m_cd == 0) begin
            m_cd = TD;
            nxt  = AMIN + ((m_addr - AMIN) + (d ? n - 1 : 1)) % n;
            if ((!d && nxt < m_addr) || (d && nxt > m_addr)) begin
              m_wrap = 1'b1;
`ifdef LED_SEQ_ONESHOT_EN
              m_mode = M_IDLE;
              m_addr = AMIN;
`else
              m_addr = nxt;
              m_step = 1'b1;
`endif
            end else begin
              m_addr = nxt;
              m_step = 1'b1;
            end
          end
        end
      end
      default: begin
        if (p) begin
          m_mode = M_IDLE;
          m_addr = AMIN;
        end else if (s) begin
          m_mode = M_RUN;
          m_cd   = TD;
        end
      end
    endcase
    m_rdv = prev && (m_mode != M_IDLE);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("addr",     32'(addr),     32'(m_addr));
    chk("en",       32'(en),       32'(m_mode != M_IDLE));
    chk("busy",     32'(busy),     32'(m_mode != M_IDLE));
    chk("step",     32'(step),     32'(m_step));
    chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
    chk("wrap",     32'(wrap),     32'(m_wrap));
  endtask

  // Inputs are driven 1 time unit after a rising edge and checked 1 unit after the next one.
  task automatic do_cycle(input bit s, input bit p, input bit d);
    start = s;
    stop  = p;
    dir   = d;
    @(posedge clk);
    model_edge(s, p, d);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    check_outputs();
  endtask

  int seq[$];
  int exp_seq[$];
  bit d;
  int k;
  bit found;

  initial begin
    model_reset();

    // 1: reset held, then released; quiet for 20 cycles
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    repeat (20) do_cycle(1'b0, 1'b0, 1'b0);

    // 2: up-count through a full wrap
    do_cycle(1'b1, 1'b0, 1'b0);
    chk("start_step", 32'(step), 32'd1);
    repeat (36) do_cycle(1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0);

    // 3: down-count, direction flipped after address 5
    d = 1'b1;
    do_cycle(1'b1, 1'b0, d);
    if (step === 1'b1) seq.push_back(int'(addr));
    for (int i = 0; i < 21; i++) begin
      do_cycle(1'b0, 1'b0, d);
      if (step === 1'b1) seq.push_back(int'(addr));
      if (m_step && m_addr == 5) d = 1'b0;
    end
`ifdef LED_SEQ_ONESHOT_EN
    exp_seq = '{7, 6, 5, 6, 7};
`else
    exp_seq = '{7, 6, 5, 6, 7, 0};
`endif
    chk("dir_seq_len", 32'(seq.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < seq.size(); i++)
      chk("dir_seq", 32'(seq[i]), 32'(exp_seq[i]));
    do_cycle(1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0);

    // 4: pause at 3, resume, next step exactly TD cycles after start
    do_cycle(1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      do_cycle(1'b0, 1'b0, 1'b0);
      if (m_step && m_addr == 3) found = 1'b1;
    end
    chk("reach_addr3", 32'(found), 32'd1);
    do_cycle(1'b0, 1'b1, 1'b0);
    repeat (10) do_cycle(1'b0, 1'b0, 1'b0);
    chk("pause_hold_addr", 32'(addr), 32'd3);
    chk("pause_hold_en", 32'(en), 32'd1);
    do_cycle(1'b1, 1'b0, 1'b0);
    k = 0;
    for (int i = 1; i <= 10 && k == 0; i++) begin
      do_cycle(1'b0, 1'b0, 1'b0);
      if (step === 1'b1) k = i;
    end
    chk("resume_latency", 32'(k), 32'(TD));
    chk("resume_addr", 32'(addr), 32'd4);

    // 5: start+stop together in RUN, PAUSE, IDLE
    do_cycle(1'b1, 1'b1, 1'b0);
    chk("pair_run_busy", 32'(busy), 32'd1);
    do_cycle(1'b1, 1'b1, 1'b0);
    chk("pair_pause_en", 32'(en), 32'd0);
    chk("pair_pause_addr", 32'(addr), 32'd0);
    do_cycle(1'b1, 1'b1, 1'b0);
    chk("pair_idle_en", 32'(en), 32'd0);

    // stop landing on the tick cycle suppresses the step
    do_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10 && m_cd != 1; i++) do_cycle(1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0);
    chk("stop_tick_step", 32'(step), 32'd0);
    chk("stop_tick_addr", 32'(addr), 32'd0);
    do_cycle(1'b0, 1'b1, 1'b0);

    // 6: asynchronous reset mid-run at address 5
    do_cycle(1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      do_cycle(1'b0, 1'b0, 1'b0);
      if (m_step && m_addr == 5) found = 1'b1;
    end
    chk("reach_addr5", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    do_cycle(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (5) do_cycle(1'b0, 1'b0, 1'b0);

    // random traffic
    d = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) d = ~d;
      do_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
